// File: rtl/alarm_pkg.sv
// Shared state encoding and default timing for the door/window alarm controller.
package alarm_pkg;

   typedef logic [2:0] state_t;

   localparam state_t DISARMED    = 3'd0;
   localparam state_t EXIT_DELAY  = 3'd1;
   localparam state_t ARMED       = 3'd2;
   localparam state_t ENTRY_DELAY = 3'd3;
   localparam state_t ALARM       = 3'd4;

   localparam int EXIT_CYCLES_DEF  = 16;
   localparam int ENTRY_CYCLES_DEF = 16;
   localparam int SIREN_CYCLES_DEF = 64;
   localparam int CNT_W_DEF        = 8;

endpackage

// File: rtl/alarm_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
// Latency 2 cycles; free-running, no backpressure.
module alarm_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/alarm_controller.sv
// Arming controller: exit/entry delays, timed siren, sticky trip flag around the sensors.
// Inputs act 2 cycles after the pin (synchronisers); outputs registered with state; no backpressure.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int EXIT_CYCLES  = EXIT_CYCLES_DEF,
   parameter int ENTRY_CYCLES = ENTRY_CYCLES_DEF,
   parameter int SIREN_CYCLES = SIREN_CYCLES_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       arm,
   input  logic       disarm,
   input  logic       door,
   input  logic       window,
   output logic       armed,
   output logic       pending,
   output logic       notify,
   output logic       tripped,
   output logic       arm_fail,
   output logic [2:0] state
);

   logic             w_a_s, w_d_s, w_dr_s, w_w_s;
   logic             w_arm_edge, w_cnt_zero, w_fail;
   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_a_prev;
   logic             r_armed, r_pending, r_notify, r_tripped, r_arm_fail;
   logic             w_armed_nxt, w_pending_nxt, w_notify_nxt, w_tripped_nxt;

   alarm_sync #(.WIDTH(1)) u_sync_arm    (.clk(clk), .rst_n(rst_n), .i_async(arm),    .o_sync(w_a_s));
   alarm_sync #(.WIDTH(1)) u_sync_disarm (.clk(clk), .rst_n(rst_n), .i_async(disarm), .o_sync(w_d_s));
   alarm_sync #(.WIDTH(1)) u_sync_door   (.clk(clk), .rst_n(rst_n), .i_async(door),   .o_sync(w_dr_s));
   alarm_sync #(.WIDTH(1)) u_sync_window (.clk(clk), .rst_n(rst_n), .i_async(window), .o_sync(w_w_s));

   // A held arm key must be released before it can arm again.
   assign w_arm_edge = w_a_s & ~r_a_prev;
   assign w_cnt_zero = (r_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= DISARMED;
         r_cnt      <= '0;
         r_a_prev   <= 1'b0;
         r_armed    <= 1'b0;
         r_pending  <= 1'b0;
         r_notify   <= 1'b0;
         r_tripped  <= 1'b0;
         r_arm_fail <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_a_prev   <= w_a_s;
         r_armed    <= w_armed_nxt;
         r_pending  <= w_pending_nxt;
         r_notify   <= w_notify_nxt;
         r_tripped  <= w_tripped_nxt;
         r_arm_fail <= w_fail;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fail      = 1'b0;
      if (w_d_s) begin
         w_state_nxt = DISARMED;
      end else begin
         case (r_state)
            DISARMED:    if (w_arm_edge) w_state_nxt = EXIT_DELAY;
            EXIT_DELAY: begin
               if (w_cnt_zero) begin
                  if (w_dr_s | w_w_s) begin
                     w_state_nxt = DISARMED;
                     w_fail      = 1'b1;
                  end else begin
                     w_state_nxt = ARMED;
                  end
               end
            end
            ARMED: begin
               if (w_w_s)       w_state_nxt = ALARM;
               else if (w_dr_s) w_state_nxt = ENTRY_DELAY;
            end
            ENTRY_DELAY: if (w_w_s | w_cnt_zero) w_state_nxt = ALARM;
            ALARM:       if (w_cnt_zero) w_state_nxt = ARMED;
            default:     w_state_nxt = DISARMED;
         endcase
      end
   end

   // Counter load and output flags are decoded from the next state so they line up with state.
   always_comb begin
      w_cnt_nxt = '0;
      if (w_state_nxt != r_state) begin
         case (w_state_nxt)
            EXIT_DELAY:  w_cnt_nxt = CNT_W'(EXIT_CYCLES - 1);
            ENTRY_DELAY: w_cnt_nxt = CNT_W'(ENTRY_CYCLES - 1);
            ALARM:       w_cnt_nxt = CNT_W'(SIREN_CYCLES - 1);
            default:     w_cnt_nxt = '0;
         endcase
      end else if (!w_cnt_zero) begin
         w_cnt_nxt = r_cnt - 1'b1;
      end

      w_armed_nxt   = (w_state_nxt == ARMED) || (w_state_nxt == ENTRY_DELAY) || (w_state_nxt == ALARM);
      w_pending_nxt = (w_state_nxt == EXIT_DELAY) || (w_state_nxt == ENTRY_DELAY);
      w_notify_nxt  = (w_state_nxt == ALARM);

      w_tripped_nxt = r_tripped;
      if (w_d_s)
         w_tripped_nxt = 1'b0;
      else if ((w_state_nxt == ALARM) && (r_state != ALARM))
         w_tripped_nxt = 1'b1;
   end

   assign armed    = r_armed;
   assign pending  = r_pending;
   assign notify   = r_notify;
   assign tripped  = r_tripped;
   assign arm_fail = r_arm_fail;
   assign state    = r_state;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed vector table, async-reset sequences, then random
// traffic against a deadline-based reference model.
module tb_alarm_controller;
   import alarm_pkg::*;

   localparam int EXIT  = 8;
   localparam int ENTRY = 6;
   localparam int SIREN = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       arm, disarm, door, window;
   logic       armed, pending, notify, tripped, arm_fail;
   logic [2:0] state;
   logic [7:0] obs;

   alarm_controller #(
      .EXIT_CYCLES (EXIT),
      .ENTRY_CYCLES(ENTRY),
      .SIREN_CYCLES(SIREN),
      .CNT_W       (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .arm     (arm),
      .disarm  (disarm),
      .door    (door),
      .window  (window),
      .armed   (armed),
      .pending (pending),
      .notify  (notify),
      .tripped (tripped),
      .arm_fail(arm_fail),
      .state   (state)
   );

   always #5 clk = ~clk;

   // {state, armed, pending, notify, tripped, arm_fail}
   assign obs = {state, armed, pending, notify, tripped, arm_fail};

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] stim;   // {arm, disarm, door, window}
      int         n;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got st/arm/pend/notif/trip/fail=%b, want %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v);
      {arm, disarm, door, window} = v;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic add(input logic [3:0] s, input int n, input logic [2:0] st, input logic [4:0] fl);
      vecs.push_back('{s, n, {st, fl}});
   endtask

   // Reference model: the synchronisers are a 2-deep queue of raw samples, and each
   // timed state records the absolute cycle at which it expires.
   logic [3:0]  m_hist[$];
   logic [2:0]  m_state;
   logic        m_a_last, m_trip, m_fail;
   int unsigned m_cycle, m_deadline;

   function automatic int unsigned dur(input logic [2:0] s);
      case (s)
         EXIT_DELAY:  return EXIT;
         ENTRY_DELAY: return ENTRY;
         ALARM:       return SIREN;
         default:     return 0;
      endcase
   endfunction

   function automatic logic [7:0] model_vec();
      logic a, p, n;
      a = (m_state == ARMED) || (m_state == ENTRY_DELAY) || (m_state == ALARM);
      p = (m_state == EXIT_DELAY) || (m_state == ENTRY_DELAY);
      n = (m_state == ALARM);
      return {m_state, a, p, n, m_trip, m_fail};
   endfunction

   task automatic model_reset();
      m_hist.delete();
      m_hist.push_back(4'b0);
      m_hist.push_back(4'b0);
      m_state    = DISARMED;
      m_a_last   = 1'b0;
      m_trip     = 1'b0;
      m_fail     = 1'b0;
      m_cycle    = 0;
      m_deadline = 0;
   endtask

   task automatic model_step(input logic [3:0] raw);
      logic [3:0] s;
      logic [2:0] nxt;
      logic       timeout;
      s = m_hist.pop_front();
      m_hist.push_back(raw);
      timeout = (dur(m_state) != 0) && (m_cycle == m_deadline);
      nxt     = m_state;
      m_fail  = 1'b0;
      if (s[2]) nxt = DISARMED;
      else begin
         case (m_state)
            DISARMED:    if (s[3] && !m_a_last) nxt = EXIT_DELAY;
            EXIT_DELAY:  if (timeout) begin
                            if (s[1] || s[0]) begin nxt = DISARMED; m_fail = 1'b1; end
                            else nxt = ARMED;
                         end
            ARMED:       if (s[0]) nxt = ALARM; else if (s[1]) nxt = ENTRY_DELAY;
            ENTRY_DELAY: if (s[0] || timeout) nxt = ALARM;
            ALARM:       if (timeout) nxt = ARMED;
            default:     nxt = DISARMED;
         endcase
      end
      if (s[2]) m_trip = 1'b0;
      else if (nxt == ALARM && m_state != ALARM) m_trip = 1'b1;
      if (nxt != m_state) m_deadline = m_cycle + dur(nxt);
      m_a_last = s[3];
      m_state  = nxt;
      m_cycle++;
   endtask

   // Arm from DISARMED and confirm the full exit delay before ARMED.
   task automatic arm_seq(input string tag);
      drive(4'b1000); tick(1);
      drive(4'b0000); tick(2);
      check({tag, "_exit_start"}, obs, {EXIT_DELAY, 5'b01000});
      tick(EXIT - 1);
      check({tag, "_exit_last"}, obs, {EXIT_DELAY, 5'b01000});
      tick(1);
      check({tag, "_armed"}, obs, {ARMED, 5'b10000});
   endtask

   logic lv_door, lv_win;

   initial begin
      rst_n = 1'b0;
      drive(4'b0000);
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", obs, 8'h00);
      rst_n = 1'b1;

      // Arm, door entry to alarm and siren timeout, window trip, failed arm,
      // simultaneous arm/disarm, disarm in exit delay, held arm key.
      add(4'b0000, 2, DISARMED,    5'b00000);
      add(4'b1000, 1, DISARMED,    5'b00000);
      add(4'b0000, 1, DISARMED,    5'b00000);
      add(4'b0000, 1, EXIT_DELAY,  5'b01000);
      add(4'b0000, 7, EXIT_DELAY,  5'b01000);
      add(4'b0000, 1, ARMED,       5'b10000);
      add(4'b0010, 1, ARMED,       5'b10000);
      add(4'b0000, 2, ENTRY_DELAY, 5'b11000);
      add(4'b0000, 5, ENTRY_DELAY, 5'b11000);
      add(4'b0000, 1, ALARM,       5'b10110);
      add(4'b0000, 9, ALARM,       5'b10110);
      add(4'b0000, 1, ARMED,       5'b10010);
      add(4'b0001, 1, ARMED,       5'b10010);
      add(4'b0000, 2, ALARM,       5'b10110);
      add(4'b0100, 1, ALARM,       5'b10110);
      add(4'b0000, 1, ALARM,       5'b10110);
      add(4'b0000, 1, DISARMED,    5'b00000);
      add(4'b1001, 1, DISARMED,    5'b00000);
      add(4'b0001, 2, EXIT_DELAY,  5'b01000);
      add(4'b0001, 7, EXIT_DELAY,  5'b01000);
      add(4'b0001, 1, DISARMED,    5'b00001);
      add(4'b0000, 1, DISARMED,    5'b00000);
      add(4'b1100, 1, DISARMED,    5'b00000);
      add(4'b0000, 3, DISARMED,    5'b00000);
      add(4'b1000, 1, DISARMED,    5'b00000);
      add(4'b0000, 2, EXIT_DELAY,  5'b01000);
      add(4'b0100, 1, EXIT_DELAY,  5'b01000);
      add(4'b0000, 2, DISARMED,    5'b00000);
      add(4'b1000, 1, DISARMED,    5'b00000);
      add(4'b1000, 3, EXIT_DELAY,  5'b01000);
      add(4'b1100, 1, EXIT_DELAY,  5'b01000);
      add(4'b1000, 8, DISARMED,    5'b00000);
      add(4'b0000, 3, DISARMED,    5'b00000);

      foreach (vecs[i]) begin
         drive(vecs[i].stim);
         tick(vecs[i].n);
         check($sformatf("vec%0d", i), obs, vecs[i].exp);
      end

      // Asynchronous reset in the middle of the entry delay.
      arm_seq("pre_entry");
      drive(4'b0010); tick(1);
      drive(4'b0000); tick(2);
      check("entry_begin", obs, {ENTRY_DELAY, 5'b11000});
      tick(2);
      #2 rst_n = 1'b0;
      #1 check("async_rst_entry", obs, 8'h00);
      @(posedge clk);
      #1 rst_n = 1'b1;
      arm_seq("after_entry_rst");

      // Asynchronous reset in the middle of the siren.
      drive(4'b0001); tick(1);
      drive(4'b0000); tick(2);
      check("alarm_begin", obs, {ALARM, 5'b10110});
      tick(3);
      #2 rst_n = 1'b0;
      #1 check("async_rst_alarm", obs, 8'h00);
      @(posedge clk);
      #1 rst_n = 1'b1;
      arm_seq("after_alarm_rst");

      // Random traffic with sensors as slowly toggling levels.
      for (int seg = 0; seg < 4; seg++) begin
         rst_n = 1'b0;
         drive(4'b0000);
         #1 check("rand_rst", obs, 8'h00);
         @(posedge clk);
         #1 rst_n = 1'b1;
         model_reset();
         lv_door = 1'b0;
         lv_win  = 1'b0;
         for (int c = 0; c < 800; c++) begin
            lv_door = lv_door ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 39) == 0);
            lv_win  = lv_win  ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 79) == 0);
            drive({($urandom_range(0, 9) == 0), ($urandom_range(0, 69) == 0), lv_door, lv_win});
            @(posedge clk);
            model_step({arm, disarm, door, window});
            #1;
            check($sformatf("rand_s%0d_c%0d", seg, c), obs, model_vec());
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
